// File: rtl/double_threshold_hysteresis.sv
// Canny double-threshold classification followed by in-place hysteresis passes.
// Accepts one NMS magnitude frame per start pulse and produces a binary edge map.
module double_threshold_hysteresis #(
    parameter int WIDTH      = 5,
    parameter int HEIGHT     = 5,
    parameter int PIX_W      = 16,
    parameter int STRONG_VAL = 255,
    parameter int MAX_PASSES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PIX_W-1:0] Z        [0:HEIGHT-1][0:WIDTH-1],
    input  logic [PIX_W-1:0] low_thr,
    input  logic [PIX_W-1:0] high_thr,
    output logic             busy,
    output logic             done,
    output logic [PIX_W-1:0] edge_map [0:HEIGHT-1][0:WIDTH-1],
    output logic [7:0]       n_passes,
    output logic             pass_sat
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

    localparam logic [1:0]       LBL_NONE   = 2'd0;
    localparam logic [1:0]       LBL_WEAK   = 2'd1;
    localparam logic [1:0]       LBL_STRONG = 2'd2;
    localparam logic [PIX_W-1:0] STRONG_PIX = PIX_W'(STRONG_VAL);
    localparam logic [7:0]       MAXP       = 8'(MAX_PASSES);
    localparam logic [RW-1:0]    LAST_ROW   = RW'(HEIGHT - 1);
    localparam logic [CW-1:0]    LAST_COL   = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CLASSIFY, HYST, FINAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    c_q, c_d;
    logic [1:0]       lab_q  [0:HEIGHT-1][0:WIDTH-1];
    logic [1:0]       lab_d  [0:HEIGHT-1][0:WIDTH-1];
    logic [PIX_W-1:0] zb_q   [0:HEIGHT-1][0:WIDTH-1];
    logic [PIX_W-1:0] zb_d   [0:HEIGHT-1][0:WIDTH-1];
    logic [PIX_W-1:0] edge_q [0:HEIGHT-1][0:WIDTH-1];
    logic [PIX_W-1:0] edge_d [0:HEIGHT-1][0:WIDTH-1];
    logic [PIX_W-1:0] low_q, low_d, high_q, high_d;
    logic [7:0]       cnt_q, cnt_d, np_q, np_d;
    logic             changed_q, changed_d;
    logic             sat_pend_q, sat_pend_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Strong map padded with a zero border so every neighbourhood stays in range.
    logic spad       [0:HEIGHT+1][0:WIDTH+1];
    logic nbr_strong [0:HEIGHT-1][0:WIDTH-1];

    always_comb begin
        for (int i = 0; i < HEIGHT + 2; i++)
            for (int j = 0; j < WIDTH + 2; j++)
                spad[i][j] = 1'b0;
        for (int i = 0; i < HEIGHT; i++)
            for (int j = 0; j < WIDTH; j++)
                spad[i+1][j+1] = (lab_q[i][j] == LBL_STRONG);
    end

    for (genvar gr = 0; gr < HEIGHT; gr++) begin : g_row
        for (genvar gc = 0; gc < WIDTH; gc++) begin : g_col
            assign nbr_strong[gr][gc] =
                spad[gr][gc]   | spad[gr][gc+1]   | spad[gr][gc+2]   |
                spad[gr+1][gc] |                    spad[gr+1][gc+2] |
                spad[gr+2][gc] | spad[gr+2][gc+1] | spad[gr+2][gc+2];
        end
    end

    logic [PIX_W-1:0] cur_z;
    logic [1:0]       cur_lab;
    logic             cur_nbr;
    logic             last_pix;

    assign cur_z    = zb_q[r_q][c_q];
    assign cur_lab  = lab_q[r_q][c_q];
    assign cur_nbr  = nbr_strong[r_q][c_q];
    assign last_pix = (r_q == LAST_ROW) && (c_q == LAST_COL);

    logic       promote;
    logic       chg;
    logic [7:0] cnt_nx;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        lab_d      = lab_q;
        zb_d       = zb_q;
        edge_d     = edge_q;
        low_d      = low_q;
        high_d     = high_q;
        cnt_d      = cnt_q;
        np_d       = np_q;
        changed_d  = changed_q;
        sat_pend_d = sat_pend_q;
        sat_d      = sat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        promote    = 1'b0;
        chg        = 1'b0;
        cnt_nx     = cnt_q + 8'd1;

        // Raster advance shared by both scanning states; wraps to (0,0).
        if (state_q == CLASSIFY || state_q == HYST) begin
            if (c_q == LAST_COL) begin
                c_d = '0;
                r_d = (r_q == LAST_ROW) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    zb_d       = Z;
                    low_d      = low_thr;
                    high_d     = high_thr;
                    cnt_d      = '0;
                    sat_pend_d = 1'b0;
                    r_d        = '0;
                    c_d        = '0;
                    busy_d     = 1'b1;
                    state_d    = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (cur_z >= high_q)     lab_d[r_q][c_q] = LBL_STRONG;
                else if (cur_z >= low_q) lab_d[r_q][c_q] = LBL_WEAK;
                else                     lab_d[r_q][c_q] = LBL_NONE;
                if (last_pix) begin
                    changed_d = 1'b0;
                    state_d   = HYST;
                end
            end
            HYST: begin
                promote = (cur_lab == LBL_WEAK) && cur_nbr;
                chg     = changed_q | promote;
                if (promote) begin
                    lab_d[r_q][c_q] = LBL_STRONG;
                    changed_d       = 1'b1;
                end
                if (last_pix) begin
                    cnt_d = cnt_nx;
                    if (chg && (cnt_nx < MAXP)) begin
                        changed_d = 1'b0;
                    end else begin
                        sat_pend_d = chg && (cnt_nx == MAXP);
                        state_d    = FINAL;
                    end
                end
            end
            FINAL: begin
                for (int i = 0; i < HEIGHT; i++)
                    for (int j = 0; j < WIDTH; j++)
                        edge_d[i][j] = (lab_q[i][j] == LBL_STRONG) ? STRONG_PIX : '0;
                np_d    = cnt_q;
                sat_d   = sat_pend_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            low_q      <= '0;
            high_q     <= '0;
            cnt_q      <= '0;
            np_q       <= '0;
            changed_q  <= 1'b0;
            sat_pend_q <= 1'b0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < HEIGHT; i++)
                for (int j = 0; j < WIDTH; j++) begin
                    lab_q[i][j]  <= LBL_NONE;
                    zb_q[i][j]   <= '0;
                    edge_q[i][j] <= '0;
                end
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            low_q      <= low_d;
            high_q     <= high_d;
            cnt_q      <= cnt_d;
            np_q       <= np_d;
            changed_q  <= changed_d;
            sat_pend_q <= sat_pend_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lab_q      <= lab_d;
            zb_q       <= zb_d;
            edge_q     <= edge_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign edge_map = edge_q;
    assign n_passes = np_q;
    assign pass_sat = sat_q;

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// Directed bench: table of frames with hand-computed edge maps, pass counts and latency,
// run on a default instance and a MAX_PASSES=3 instance sharing the same stimulus.
module tb_double_threshold_hysteresis;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] z_in [0:H-1][0:W-1];
    logic [15:0] lo = '0, hi = '0;

    logic        busy, done, psat;
    logic [15:0] emap [0:H-1][0:W-1];
    logic [7:0]  np;
    logic        s_busy, s_done, s_psat;
    logic [15:0] s_emap [0:H-1][0:W-1];
    logic [7:0]  s_np;

    always #5 clk = ~clk;

    double_threshold_hysteresis #(.WIDTH(W), .HEIGHT(H), .PIX_W(16), .STRONG_VAL(255), .MAX_PASSES(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .Z(z_in), .low_thr(lo), .high_thr(hi),
        .busy(busy), .done(done), .edge_map(emap), .n_passes(np), .pass_sat(psat));

    double_threshold_hysteresis #(.WIDTH(W), .HEIGHT(H), .PIX_W(16), .STRONG_VAL(255), .MAX_PASSES(3)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .Z(z_in), .low_thr(lo), .high_thr(hi),
        .busy(s_busy), .done(s_done), .edge_map(s_emap), .n_passes(s_np), .pass_sat(s_psat));

    typedef struct packed {
        logic [N-1:0][15:0] z;
        logic [15:0]        lo;
        logic [15:0]        hi;
        logic [N-1:0]       e;    // expected strong map, default instance
        logic [N-1:0]       es;   // expected strong map, MAX_PASSES=3 instance
        logic [7:0]         np;
        logic [7:0]         nps;
        logic               st;
        logic               sts;
        logic               hs;   // exercise ignored enables while busy / in DONE
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void set_row(input int v, input int r, input int p0, input int p1,
                                    input int p2, input int p3, input int p4);
        vecs[v].z[r*W+0] = 16'(p0);
        vecs[v].z[r*W+1] = 16'(p1);
        vecs[v].z[r*W+2] = 16'(p2);
        vecs[v].z[r*W+3] = 16'(p3);
        vecs[v].z[r*W+4] = 16'(p4);
    endfunction

    // b[4] is column 0
    function automatic void set_exp(input int v, input bit sat, input int r, input logic [4:0] b);
        for (int c = 0; c < W; c++) begin
            if (sat) vecs[v].es[r*W+c] = b[4-c];
            else     vecs[v].e[r*W+c]  = b[4-c];
        end
    endfunction

    task automatic chk_map(input string nm, input bit sat, input logic [N-1:0] e);
        int bad;
        logic [15:0] got, exp;
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                got = sat ? s_emap[r][c] : emap[r][c];
                exp = e[r*W+c] ? 16'd255 : 16'd0;
                if (got != exp) begin
                    if (bad == 0) $display("FAIL %s pixel (%0d,%0d): got %0d expected %0d", nm, r, c, got, exp);
                    bad++;
                end
            end
        chk(nm, bad, 0);
    endtask

    task automatic run_vec(input int v);
        int cnt, s_lat;
        bit got;
        @(negedge clk);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                z_in[r][c] = vecs[v].z[r*W+c];
        lo = vecs[v].lo;
        hi = vecs[v].hi;
        enable = 1'b1;
        @(posedge clk);
        cnt = 0; s_lat = 0; got = 1'b0;
        while (cnt < 2000 && !got) begin
            @(negedge clk);
            cnt++;
            enable = 1'b0;
            if (cnt == 1) begin
                chk("busy_after_accept", int'(busy), 1);
                // inputs change after capture; frame must be unaffected
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        z_in[r][c] = 16'hFFFF;
                lo = 16'd0;
                hi = 16'd0;
            end
            if (vecs[v].hs && cnt == 30) enable = 1'b1;
            if (s_done && s_lat == 0) s_lat = cnt;
            if (done) got = 1'b1;
        end
        if (!got) $display("FAIL done_timeout vec %0d: got no done expected done", v);
        chk($sformatf("latency_v%0d", v), cnt, 2 + N * (1 + int'(vecs[v].np)));
        chk($sformatf("busy_at_done_v%0d", v), int'(busy), 0);
        chk_map($sformatf("edge_map_v%0d", v), 1'b0, vecs[v].e);
        chk($sformatf("n_passes_v%0d", v), int'(np), int'(vecs[v].np));
        chk($sformatf("pass_sat_v%0d", v), int'(psat), int'(vecs[v].st));
        chk($sformatf("sat_latency_v%0d", v), s_lat, 2 + N * (1 + int'(vecs[v].nps)));
        chk_map($sformatf("sat_edge_map_v%0d", v), 1'b1, vecs[v].es);
        chk($sformatf("sat_n_passes_v%0d", v), int'(s_np), int'(vecs[v].nps));
        chk($sformatf("sat_pass_sat_v%0d", v), int'(s_psat), int'(vecs[v].sts));
        if (vecs[v].hs) enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk($sformatf("done_one_cycle_v%0d", v), int'(done), 0);
        if (vecs[v].hs) begin
            chk("enable_in_done_ignored", int'(busy), 0);
            @(negedge clk);
            chk("still_idle_after_done", int'(busy), 0);
            chk_map("edge_map_held", 1'b0, vecs[v].e);
        end
    endtask

    initial begin
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                z_in[r][c] = '0;
        for (int v = 0; v < NV; v++) vecs[v] = '0;

        // 0: typical NMS output
        set_row(0, 1, 0, 100, 100, 100, 0);
        set_row(0, 2, 0, 100, 255, 100, 0);
        set_row(0, 3, 0, 0, 100, 100, 0);
        vecs[0].lo = 16'd50; vecs[0].hi = 16'd200;
        for (int s = 0; s < 2; s++) begin
            set_exp(0, s[0], 1, 5'b01110);
            set_exp(0, s[0], 2, 5'b01110);
            set_exp(0, s[0], 3, 5'b00110);
        end
        vecs[0].np = 8'd2; vecs[0].nps = 8'd2;

        // 1: weak chain promoted right-to-left, one pixel per pass
        set_row(1, 0, 100, 100, 100, 100, 255);
        vecs[1].lo = 16'd50; vecs[1].hi = 16'd200;
        set_exp(1, 1'b0, 0, 5'b11111);
        set_exp(1, 1'b1, 0, 5'b01111);
        vecs[1].np = 8'd5; vecs[1].nps = 8'd3; vecs[1].sts = 1'b1;

        // 2: inclusive threshold boundaries
        set_row(2, 0, 50, 0, 49, 0, 0);
        set_row(2, 1, 0, 0, 200, 0, 0);
        set_row(2, 3, 0, 0, 0, 50, 0);
        set_row(2, 4, 0, 0, 0, 0, 200);
        vecs[2].lo = 16'd50; vecs[2].hi = 16'd200;
        for (int s = 0; s < 2; s++) begin
            set_exp(2, s[0], 1, 5'b00100);
            set_exp(2, s[0], 3, 5'b00010);
            set_exp(2, s[0], 4, 5'b00001);
        end
        vecs[2].np = 8'd2; vecs[2].nps = 8'd2;

        // 3: low > high, nothing can be weak
        vecs[3].z = vecs[2].z;
        vecs[3].lo = 16'd300; vecs[3].hi = 16'd200;
        for (int s = 0; s < 2; s++) begin
            set_exp(3, s[0], 1, 5'b00100);
            set_exp(3, s[0], 4, 5'b00001);
        end
        vecs[3].np = 8'd1; vecs[3].nps = 8'd1;

        // 4: chain again with stray enables while busy and in DONE
        vecs[4] = vecs[1];
        vecs[4].hs = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_n_passes", int'(np), 0);
        chk("reset_pass_sat", int'(psat), 0);
        chk_map("reset_edge_map", 1'b0, '0);

        run_vec(0);

        // reset while classifying a frame
        @(negedge clk);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                z_in[r][c] = vecs[1].z[r*W+c];
        lo = 16'd50; hi = 16'd200;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_n_passes", int'(np), 0);
        chk("midreset_pass_sat", int'(psat), 0);
        chk_map("midreset_edge_map", 1'b0, '0);
        begin
            int seen_done;
            seen_done = 0;
            repeat (200) begin
                @(negedge clk);
                if (done || busy) seen_done++;
            end
            chk("aborted_frame_silent", seen_done, 0);
        end

        for (int v = 0; v < NV; v++) run_vec(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
